flit_sink_mc: RTL

- Parametrised multi-VC traffic sink for mesh verification benches. Successor to the single-mode credit sink.
- Accepts flits from a router output channel and buffers them in per-VC FIFOs. Drains one flit per cycle under a selectable consumption mode and returns one credit per drained flit.
- Checks head/tail framing per VC, keeps saturating flit and packet counters, and raises sticky error flags.

---
 rtl/flit_sink_mc_if.sv | 29 ++
 rtl/flit_sink_mc.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/flit_sink_mc_if.sv
// flit_sink_mc_if: router-to-sink channel bundling the flit input, the credit return and the consumed-flit monitor
//   master: drives flit_valid/head/tail/vc/data; observes credit_* and out_*
//   slave : observes flit_*; drives credit_valid/credit_vc and out_valid/vc/head/tail/data
interface flit_sink_mc_if #(
    parameter int num_vcs = 4,
    parameter int flit_data_width = 64
);
    localparam int vc_w = num_vcs > 1 ? $clog2(num_vcs) : 1;
    logic flit_valid;
    logic flit_head;
    logic flit_tail;
    logic [vc_w-1:0] flit_vc;
    logic [flit_data_width-1:0] flit_data;
    logic credit_valid;
    logic [vc_w-1:0] credit_vc;
    logic out_valid;
    logic [vc_w-1:0] out_vc;
    logic out_head;
    logic out_tail;
    logic [flit_data_width-1:0] out_data;
    modport master (
        output flit_valid, flit_head, flit_tail, flit_vc, flit_data,
        input  credit_valid, credit_vc, out_valid, out_vc, out_head, out_tail, out_data
    );
    modport slave (
        input  flit_valid, flit_head, flit_tail, flit_vc, flit_data,
        output credit_valid, credit_vc, out_valid, out_vc, out_head, out_tail, out_data
    );
endinterface

// File: rtl/flit_sink_mc.sv
// flit_sink_mc: multi-VC flit sink with per-VC FIFOs, mode-selectable round-robin drain, credit return and framing checks
//   clk, reset      : clock, asynchronous active-high reset
//   bus (slave)     : flit input, credit return, registered consumed-flit monitor
//   consume_mode    : 0 always, 1 random (lfsr[7:0] < consume_thresh), 2 stall, 3 burst 8 on / 8 off
//   consume_thresh  : random-mode threshold
//   flit_count      : saturating count of consumed flits
//   pkt_count       : saturating count of consumed packet tails
//   error           : sticky [0] overflow, [1] framing, [2] bad VC, [3] length
//   Define FLIT_SINK_MC_LEN_CHECK_EN to build the per-VC packet length checker (error[3]).
module flit_sink_mc #(
    parameter int num_vcs = 4,
    parameter int depth_per_vc = 4,
    parameter int flit_data_width = 64,
    parameter int count_width = 32,
    parameter logic [15:0] lfsr_seed = 16'hACE1
) (
    input  logic clk,
    input  logic reset,
    flit_sink_mc_if.slave bus,
    input  logic [1:0] consume_mode,
    input  logic [7:0] consume_thresh,
    output logic [count_width-1:0] flit_count,
    output logic [count_width-1:0] pkt_count,
    output logic [3:0] error
);
    localparam int vc_w = num_vcs > 1 ? $clog2(num_vcs) : 1;
    localparam int aw = $clog2(depth_per_vc);
    typedef enum logic {IDLE, INPKT} frame_t;
    logic [flit_data_width+1:0] mem [num_vcs][depth_per_vc];
    logic [aw:0] wp [num_vcs];
    logic [aw:0] rp [num_vcs];
    frame_t frame [num_vcs];
    logic [num_vcs-1:0] full, empty;
    logic [vc_w-1:0] rr, sel;
    logic [15:0] lfsr;
    logic [3:0] burst;
    logic [1:0] mode_q;
    logic [7:0] thresh_q;
    logic [2:0] err;
    logic vc_ok, push, consume, any, pop;
    logic p_head, p_tail;
    logic [flit_data_width-1:0] p_data;
    logic frame_err, pkt_inc;
    frame_t frame_nxt;
    // Pointers carry one extra wrap bit so full and empty are distinguishable
    always_comb begin
        for (int v = 0; v < num_vcs; v++) begin
            full[v] = (wp[v] - rp[v]) == (aw+1)'(depth_per_vc);
            empty[v] = wp[v] == rp[v];
        end
    end
    assign vc_ok = {1'b0, bus.flit_vc} < (vc_w+1)'(num_vcs);
    assign push = bus.flit_valid && vc_ok && !full[bus.flit_vc];
    assign consume = mode_q == 2'd0 || (mode_q == 2'd1 && lfsr[7:0] < thresh_q) || (mode_q == 2'd3 && !burst[3]);
    // Scan downward so the last hit is the first non-empty VC at or after rr
    always_comb begin
        sel = rr;
        any = 1'b0;
        for (int i = num_vcs - 1; i >= 0; i--) begin
            if (!empty[(int'(rr) + i) % num_vcs]) begin
                any = 1'b1;
                sel = vc_w'((int'(rr) + i) % num_vcs);
            end
        end
    end
    assign pop = consume && any;
    assign {p_head, p_tail, p_data} = mem[sel][rp[sel][aw-1:0]];
    assign frame_err = p_head ? frame[sel] == INPKT : frame[sel] == IDLE;
    assign pkt_inc = p_tail && (p_head || frame[sel] == INPKT);
    assign frame_nxt = p_tail ? IDLE : p_head ? INPKT : frame[sel];
    always_ff @(posedge clk) begin
        if (push)
            mem[bus.flit_vc][wp[bus.flit_vc][aw-1:0]] <= {bus.flit_head, bus.flit_tail, bus.flit_data};
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int v = 0; v < num_vcs; v++) begin
                wp[v] <= '0;
                rp[v] <= '0;
                frame[v] <= IDLE;
            end
            rr <= '0;
            lfsr <= lfsr_seed;
            burst <= '0;
            mode_q <= '0;
            thresh_q <= '0;
            err <= '0;
            flit_count <= '0;
            pkt_count <= '0;
            bus.credit_valid <= 1'b0;
            bus.credit_vc <= '0;
            bus.out_valid <= 1'b0;
            bus.out_vc <= '0;
            bus.out_head <= 1'b0;
            bus.out_tail <= 1'b0;
            bus.out_data <= '0;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            burst <= burst + 4'd1;
            mode_q <= consume_mode;
            thresh_q <= consume_thresh;
            err[0] <= err[0] | (bus.flit_valid && vc_ok && full[bus.flit_vc]);
            err[1] <= err[1] | (pop && frame_err);
            err[2] <= err[2] | (bus.flit_valid && !vc_ok);
            for (int v = 0; v < num_vcs; v++) begin
                if (push && bus.flit_vc == vc_w'(v))
                    wp[v] <= wp[v] + (aw+1)'(1);
                if (pop && sel == vc_w'(v)) begin
                    rp[v] <= rp[v] + (aw+1)'(1);
                    frame[v] <= frame_nxt;
                end
            end
            if (pop)
                rr <= sel == vc_w'(num_vcs - 1) ? '0 : sel + vc_w'(1);
            flit_count <= flit_count + count_width'(pop && !(&flit_count));
            pkt_count <= pkt_count + count_width'(pop && pkt_inc && !(&pkt_count));
            bus.out_valid <= pop;
            bus.credit_valid <= pop;
            if (pop) begin
                bus.credit_vc <= sel;
                bus.out_vc <= sel;
                bus.out_head <= p_head;
                bus.out_tail <= p_tail;
                bus.out_data <= p_data;
            end
        end
    end
`ifdef FLIT_SINK_MC_LEN_CHECK_EN
    logic [7:0] len_exp [num_vcs];
    logic [7:0] len_cnt [num_vcs];
    logic [7:0] exp_n, cnt_n;
    logic len_bad, len_err;
    // A head restarts the count; orphan flits in IDLE are framing errors and skip the length check
    assign exp_n = p_head ? (p_data[7:0] == 8'd0 ? 8'd1 : p_data[7:0]) : len_exp[sel];
    assign cnt_n = p_head ? 8'd1 : len_cnt[sel] + 8'd1;
    assign len_bad = (p_head || frame[sel] == INPKT) && (p_tail ? cnt_n != exp_n : cnt_n == exp_n);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int v = 0; v < num_vcs; v++) begin
                len_exp[v] <= 8'd1;
                len_cnt[v] <= '0;
            end
            len_err <= 1'b0;
        end else if (pop) begin
            len_exp[sel] <= exp_n;
            len_cnt[sel] <= cnt_n;
            len_err <= len_err | len_bad;
        end
    end
    assign error = {len_err, err};
`else
    assign error = {1'b0, err};
`endif
endmodule
